// File: rtl/key_event_queue.sv
// key_event_queue: keypad front-end for the maze game.
// Synchronises and debounces active-low buttons, turns presses (and optional
// auto-repeats while held) into move events, and queues them in a small FIFO
// drained by the game FSM through a valid/ready handshake.
module key_event_queue #(
    parameter int NUM_KEYS     = 4,
    parameter int IDX_W        = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 1024,
    parameter int REPEAT_RATE  = 256,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [NUM_KEYS-1:0] i_Key,
    input  logic                i_EvtReady,
    input  logic                i_OvfClr,
    output logic                o_EvtValid,
    output logic [IDX_W-1:0]    o_EvtIdx,
    output logic                o_EvtRpt,
    output logic [NUM_KEYS-1:0] o_KeyLevel,
    output logic                o_Overflow,
    output logic [IDX_W:0]      o_Count
);

    localparam int DB_W   = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RC_W   = $clog2(RC_MAX + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ENT_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_DELAY    = 2'd1,
        ST_REPEAT   = 2'd2
    } key_state_t;

    // Synchroniser stages; preset to 1 so a reset looks like "all released".
    logic [NUM_KEYS-1:0] sync_p0;
    logic [NUM_KEYS-1:0] sync_p1;
    logic [NUM_KEYS-1:0] pressed;

    // Debounce state.
    logic [DB_W-1:0]     db_cnt [NUM_KEYS];
    logic [NUM_KEYS-1:0] stable;

    // Per-channel press / auto-repeat FSM.
    key_state_t          state_q [NUM_KEYS];
    key_state_t          state_d [NUM_KEYS];
    logic [RC_W-1:0]     rcnt_q  [NUM_KEYS];
    logic [RC_W-1:0]     rcnt_d  [NUM_KEYS];
    logic [NUM_KEYS-1:0] evt_set;
    logic [NUM_KEYS-1:0] evt_rpt;

    // Pending events waiting for the arbiter.
    logic [NUM_KEYS-1:0] pend;
    logic [NUM_KEYS-1:0] pend_rpt;
    logic [NUM_KEYS-1:0] grant;
    logic                gnt_vld;
    logic [IDX_W-1:0]    gnt_idx;
    logic                gnt_rpt;

    // Event FIFO.
    logic [ENT_W-1:0]    mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [PTR_W-1:0]    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_d;
    logic [IDX_W:0]      count_d;
    logic [ENT_W-1:0]    push_data;
    logic [ENT_W-1:0]    head_d;
    logic                full;
    logic                pop;
    logic                push;
    logic                drop;

    // Two-flop synchroniser for the asynchronous button inputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= i_Key;
            sync_p1 <= sync_p0;
        end
    end

    assign pressed = ~sync_p1;

    // --- stage boundary: synchronised level -> debounced level ---

    // Debounce: a level change is accepted only after DEBOUNCE_CYC consecutive differing samples.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stable <= '0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                if (pressed[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    stable[i] <= pressed[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Registered copy of the debounced level; also the input of the press FSM.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_KeyLevel <= '0;
        end else begin
            o_KeyLevel <= stable;
        end
    end

    // --- stage boundary: debounced level -> press / repeat events ---

    // Press FSM state and repeat counter registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= ST_RELEASED;
                rcnt_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                state_q[i] <= state_d[i];
                rcnt_q[i]  <= rcnt_d[i];
            end
        end
    end

    // Press FSM next state: press event on entry to DELAY, repeat events from DELAY/REPEAT timers.
    always_comb begin
        for (int i = 0; i < NUM_KEYS; i++) begin
            state_d[i] = state_q[i];
            rcnt_d[i]  = rcnt_q[i];
            evt_set[i] = 1'b0;
            evt_rpt[i] = 1'b0;
            case (state_q[i])
                ST_RELEASED: begin
                    rcnt_d[i] = '0;
                    if (o_KeyLevel[i]) begin
                        state_d[i] = ST_DELAY;
                        evt_set[i] = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (!o_KeyLevel[i]) begin
                        state_d[i] = ST_RELEASED;
                        rcnt_d[i]  = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rcnt_q[i] == RC_W'(REPEAT_DELAY - 1)) begin
                            state_d[i] = ST_REPEAT;
                            rcnt_d[i]  = '0;
                            evt_set[i] = 1'b1;
                            evt_rpt[i] = 1'b1;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + RC_W'(1);
                        end
                    end
                end
                ST_REPEAT: begin
                    if (!o_KeyLevel[i]) begin
                        state_d[i] = ST_RELEASED;
                        rcnt_d[i]  = '0;
                    end else if (rcnt_q[i] == RC_W'(REPEAT_RATE - 1)) begin
                        rcnt_d[i]  = '0;
                        evt_set[i] = 1'b1;
                        evt_rpt[i] = 1'b1;
                    end else begin
                        rcnt_d[i] = rcnt_q[i] + RC_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_RELEASED;
                    rcnt_d[i]  = '0;
                end
            endcase
        end
    end

    // --- stage boundary: events -> pending bits -> arbiter ---

    // Lowest-index pending channel wins the single FIFO write slot this cycle.
    always_comb begin
        gnt_idx = '0;
        gnt_rpt = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                gnt_idx = IDX_W'(i);
                gnt_rpt = pend_rpt[i];
            end
        end
    end

    assign gnt_vld   = |pend;
    assign grant     = pend & (~pend + NUM_KEYS'(1));
    assign push_data = {gnt_rpt, gnt_idx};

    // Pending bits: granted bit clears, new events set (a second event merges and refreshes rpt).
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~grant) | evt_set;
        end
    end

    // Repeat flag of each pending event; only meaningful while its pend bit is set.
    always_ff @(posedge Clk) begin
        pend_rpt <= (pend_rpt & ~evt_set) | (evt_rpt & evt_set);
    end

    // --- stage boundary: arbiter -> event FIFO ---

    assign pop  = o_EvtValid & i_EvtReady;
    assign full = (o_Count == (IDX_W + 1)'(FIFO_DEPTH));
    assign push = gnt_vld & (~full | pop);
    assign drop = gnt_vld & full & ~pop;

    // FIFO next-state: pointers, occupancy and the entry that becomes the new head.
    always_comb begin
        rd_ptr_d = rd_ptr + PTR_W'(pop);
        wr_ptr_d = wr_ptr + PTR_W'(push);
        count_d  = o_Count;
        case ({push, pop})
            2'b10:   count_d = o_Count + (IDX_W + 1)'(1);
            2'b01:   count_d = o_Count - (IDX_W + 1)'(1);
            default: count_d = o_Count;
        endcase
        if (push && (wr_ptr == rd_ptr_d)) begin
            head_d = push_data;
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // FIFO storage write at the tail.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // FIFO control and registered head outputs.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_Count    <= '0;
            o_EvtValid <= 1'b0;
            o_EvtIdx   <= '0;
            o_EvtRpt   <= 1'b0;
        end else begin
            wr_ptr     <= wr_ptr_d;
            rd_ptr     <= rd_ptr_d;
            o_Count    <= count_d;
            o_EvtValid <= (count_d != '0);
            if (count_d != '0) begin
                {o_EvtRpt, o_EvtIdx} <= head_d;
            end
        end
    end

    // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            o_Overflow <= 1'b0;
        end else if (drop) begin
            o_Overflow <= 1'b1;
        end else if (i_OvfClr) begin
            o_Overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed testbench for key_event_queue (DEBOUNCE_CYC=4, REPEAT_DELAY=40, REPEAT_RATE=10, FIFO_DEPTH=4).
module tb_key_event_queue;

    logic       Clk;
    logic       Rst;
    logic [3:0] i_Key;
    logic       i_EvtReady;
    logic       i_OvfClr;
    logic       o_EvtValid;
    logic [1:0] o_EvtIdx;
    logic       o_EvtRpt;
    logic [3:0] o_KeyLevel;
    logic       o_Overflow;
    logic [2:0] o_Count;

    int checks;
    int errors;

    key_event_queue #(
        .NUM_KEYS     (4),
        .IDX_W        (2),
        .DEBOUNCE_CYC (4),
        .REPEAT_EN    (1),
        .REPEAT_DELAY (40),
        .REPEAT_RATE  (10),
        .FIFO_DEPTH   (4)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_Key      (i_Key),
        .i_EvtReady (i_EvtReady),
        .i_OvfClr   (i_OvfClr),
        .o_EvtValid (o_EvtValid),
        .o_EvtIdx   (o_EvtIdx),
        .o_EvtRpt   (o_EvtRpt),
        .o_KeyLevel (o_KeyLevel),
        .o_Overflow (o_Overflow),
        .o_Count    (o_Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Advance n clock edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic test_reset;
        i_Key = 4'b1111; i_EvtReady = 1'b0; i_OvfClr = 1'b0;
        Rst = 1'b1;
        #2 Rst = 1'b0;
        tick(3);
        checks++; if (o_EvtValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_EvtValid); end
        checks++; if (o_EvtIdx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", o_EvtIdx); end
        checks++; if (o_EvtRpt !== 1'b0) begin errors++; $display("FAIL reset_rpt: got %b expected 0", o_EvtRpt); end
        checks++; if (o_KeyLevel !== 4'b0000) begin errors++; $display("FAIL reset_level: got %b expected 0000", o_KeyLevel); end
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", o_Overflow); end
        checks++; if (o_Count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_Count); end
        Rst = 1'b1;
        tick(10);
        checks++; if (o_KeyLevel !== 4'b0000) begin errors++; $display("FAIL post_reset_level: got %b expected 0000", o_KeyLevel); end
        checks++; if (o_EvtValid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b expected 0", o_EvtValid); end
    endtask

    task automatic test_single_press;
        int       n_evt;
        int       first_k;
        logic [1:0] idx;
        logic     rpt;
        n_evt = 0; first_k = -1; idx = 2'd3; rpt = 1'b1;
        i_Key = 4'b1101; i_EvtReady = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick(1);
            if (k == 5) begin
                checks++; if (o_KeyLevel !== 4'b0000) begin errors++; $display("FAIL single_level_early: got %b expected 0000", o_KeyLevel); end
            end
            if (k == 6) begin
                checks++; if (o_KeyLevel !== 4'b0010) begin errors++; $display("FAIL single_level: got %b expected 0010", o_KeyLevel); end
            end
            if (o_EvtValid) begin
                if (n_evt == 0) begin first_k = k; idx = o_EvtIdx; rpt = o_EvtRpt; end
                n_evt++;
            end
            if (k == 19) i_Key = 4'b1111;
        end
        checks++; if (n_evt !== 1) begin errors++; $display("FAIL single_evt_count: got %0d expected 1", n_evt); end
        checks++; if (first_k !== 8) begin errors++; $display("FAIL single_evt_latency: got %0d expected 8", first_k); end
        checks++; if (idx !== 2'd1) begin errors++; $display("FAIL single_evt_idx: got %0d expected 1", idx); end
        checks++; if (rpt !== 1'b0) begin errors++; $display("FAIL single_evt_rpt: got %b expected 0", rpt); end
        checks++; if (o_Count !== 3'd0) begin errors++; $display("FAIL single_count: got %0d expected 0", o_Count); end
        checks++; if (o_KeyLevel !== 4'b0000) begin errors++; $display("FAIL single_release_level: got %b expected 0000", o_KeyLevel); end
    endtask

    task automatic test_glitch;
        logic seen_lvl;
        logic seen_evt;
        seen_lvl = 1'b0; seen_evt = 1'b0;
        i_Key = 4'b1110;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (k == 2) i_Key = 4'b1111;
            if (o_KeyLevel[0]) seen_lvl = 1'b1;
            if (o_EvtValid) seen_evt = 1'b1;
        end
        checks++; if (seen_lvl !== 1'b0) begin errors++; $display("FAIL glitch_level: got %b expected 0", seen_lvl); end
        checks++; if (seen_evt !== 1'b0) begin errors++; $display("FAIL glitch_event: got %b expected 0", seen_evt); end
    endtask

    task automatic test_repeat;
        int   n_evt;
        int   t_evt [16];
        logic r_evt [16];
        n_evt = 0;
        i_Key = 4'b1110; i_EvtReady = 1'b1;
        for (int k = 0; k < 130; k++) begin
            tick(1);
            if (k == 99) i_Key = 4'b1111;
            if (o_EvtValid) begin
                if (n_evt < 16) begin t_evt[n_evt] = k; r_evt[n_evt] = o_EvtRpt; end
                n_evt++;
            end
        end
        checks++; if (n_evt !== 7) begin errors++; $display("FAIL repeat_count: got %0d expected 7", n_evt); end
        if (n_evt >= 2) begin
            checks++; if (r_evt[0] !== 1'b0) begin errors++; $display("FAIL repeat_first_rpt: got %b expected 0", r_evt[0]); end
            checks++; if (t_evt[1] - t_evt[0] !== 40) begin errors++; $display("FAIL repeat_delay: got %0d expected 40", t_evt[1] - t_evt[0]); end
            for (int j = 1; j < n_evt && j < 16; j++) begin
                checks++; if (r_evt[j] !== 1'b1) begin errors++; $display("FAIL repeat_rpt_%0d: got %b expected 1", j, r_evt[j]); end
                if (j >= 2) begin
                    checks++; if (t_evt[j] - t_evt[j-1] !== 10) begin errors++; $display("FAIL repeat_rate_%0d: got %0d expected 10", j, t_evt[j] - t_evt[j-1]); end
                end
            end
        end
        tick(10);
    endtask

    task automatic test_back_to_back;
        i_EvtReady = 1'b0;
        i_Key = 4'b0110;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (k == 8) begin
                checks++; if (o_Count !== 3'd1) begin errors++; $display("FAIL b2b_count_first: got %0d expected 1", o_Count); end
            end
            if (k == 9) begin
                checks++; if (o_Count !== 3'd2) begin errors++; $display("FAIL b2b_count_second: got %0d expected 2", o_Count); end
            end
        end
        i_Key = 4'b1111;
        checks++; if (o_Count !== 3'd2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", o_Count); end
        checks++; if ({o_EvtValid, o_EvtIdx, o_EvtRpt} !== 4'b1_00_0) begin errors++; $display("FAIL b2b_head0: got v%b i%0d r%b expected v1 i0 r0", o_EvtValid, o_EvtIdx, o_EvtRpt); end
        i_EvtReady = 1'b1;
        tick(1);
        checks++; if ({o_EvtValid, o_EvtIdx, o_EvtRpt} !== 4'b1_11_0) begin errors++; $display("FAIL b2b_head1: got v%b i%0d r%b expected v1 i3 r0", o_EvtValid, o_EvtIdx, o_EvtRpt); end
        checks++; if (o_Count !== 3'd1) begin errors++; $display("FAIL b2b_count_pop1: got %0d expected 1", o_Count); end
        tick(1);
        i_EvtReady = 1'b0;
        checks++; if (o_EvtValid !== 1'b0) begin errors++; $display("FAIL b2b_empty_valid: got %b expected 0", o_EvtValid); end
        checks++; if (o_Count !== 3'd0) begin errors++; $display("FAIL b2b_empty_count: got %0d expected 0", o_Count); end
        i_EvtReady = 1'b1;
        tick(2);
        i_EvtReady = 1'b0;
        checks++; if (o_Count !== 3'd0) begin errors++; $display("FAIL b2b_ready_empty: got %0d expected 0", o_Count); end
        tick(15);
    endtask

    task automatic test_overflow;
        logic [3:0] key;
        i_EvtReady = 1'b0;
        for (int p = 0; p < 6; p++) begin
            key = 4'b1111;
            key[p % 4] = 1'b0;
            i_Key = key;
            tick(10);
            i_Key = 4'b1111;
            tick(12);
            if (p == 3) begin
                checks++; if (o_Count !== 3'd4) begin errors++; $display("FAIL ovf_count_full: got %0d expected 4", o_Count); end
                checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_not_yet: got %b expected 0", o_Overflow); end
            end
        end
        checks++; if (o_Count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", o_Count); end
        checks++; if (o_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", o_Overflow); end
        checks++; if ({o_EvtValid, o_EvtIdx} !== 3'b1_00) begin errors++; $display("FAIL ovf_head: got v%b i%0d expected v1 i0", o_EvtValid, o_EvtIdx); end
        i_OvfClr = 1'b1;
        tick(1);
        i_OvfClr = 1'b0;
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", o_Overflow); end

        // Push and pop in the same cycle while full.
        i_Key = 4'b1011;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (k == 7) i_EvtReady = 1'b1;
            if (k == 8) begin
                i_EvtReady = 1'b0;
                checks++; if (o_Count !== 3'd4) begin errors++; $display("FAIL full_pushpop_count: got %0d expected 4", o_Count); end
                checks++; if (o_EvtIdx !== 2'd1) begin errors++; $display("FAIL full_pushpop_head: got %0d expected 1", o_EvtIdx); end
            end
        end
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf: got %b expected 0", o_Overflow); end
        i_Key = 4'b1111;
        tick(12);

        // Drop coinciding with clear: the drop wins.
        i_Key = 4'b0111;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (k == 7) i_OvfClr = 1'b1;
            if (k == 8) begin
                i_OvfClr = 1'b0;
                checks++; if (o_Overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop_vs_clear: got %b expected 1", o_Overflow); end
            end
        end
        i_Key = 4'b1111;
        tick(3);

        // Asynchronous reset mid-run empties the queue at once.
        #2 Rst = 1'b0;
        #1;
        checks++; if (o_EvtValid !== 1'b0) begin errors++; $display("FAIL async_rst_valid: got %b expected 0", o_EvtValid); end
        checks++; if (o_Count !== 3'd0) begin errors++; $display("FAIL async_rst_count: got %0d expected 0", o_Count); end
        checks++; if (o_Overflow !== 1'b0) begin errors++; $display("FAIL async_rst_ovf: got %b expected 0", o_Overflow); end
        tick(2);
        Rst = 1'b1;
        tick(20);
        checks++; if (o_EvtValid !== 1'b0) begin errors++; $display("FAIL post_rst_valid: got %b expected 0", o_EvtValid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single_press();
        test_glitch();
        test_repeat();
        test_back_to_back();
        test_overflow();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
